// File: rtl/rot_cmd_loader.sv
// rot_cmd_loader: debounces the load/clear buttons and walks a capture FSM that stages a/amt/lr for the rotator.
// Define ROT_CMD_AUTO_STEP_EN to build a periodic amt auto-step while in RUN.
module rot_cmd_loader #(
  parameter int unsigned DB_TICKS   = 1_000_000,
  parameter int unsigned STEP_TICKS = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw,
  input  logic        btn_ld,
  input  logic        btn_clr,
  output logic [15:0] a,
  output logic [3:0]  amt,
  output logic        lr,
  output logic        valid,
  output logic [1:0]  phase
);

  localparam int unsigned     DB_W   = $clog2(DB_TICKS);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_TICKS - 1);

  if (DB_TICKS < 2 || STEP_TICKS < 2) begin : g_param_check
    $error("rot_cmd_loader: DB_TICKS and STEP_TICKS must both be >= 2");
  end

  typedef enum logic [1:0] {
    LOAD_LO  = 2'd0,
    LOAD_HI  = 2'd1,
    LOAD_CFG = 2'd2,
    RUN      = 2'd3
  } state_t;

  // Bit 0 is the load button, bit 1 the clear button.
  logic [1:0]           btn_raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           db_q, db_d;
  logic [1:0]           db_dly_q;
  logic [1:0]           pulse_q;
  logic [1:0][DB_W-1:0] cnt_q, cnt_d;
  logic                 ld_p, clr_p;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [3:0]  amt_q, amt_d;
  logic        lr_q, lr_d;

  assign btn_raw = {btn_clr, btn_ld};
  assign ld_p    = pulse_q[0];
  assign clr_p   = pulse_q[1];

`ifdef ROT_CMD_AUTO_STEP_EN
  localparam int unsigned       STEP_W   = $clog2(STEP_TICKS);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_TICKS - 1);

  logic [STEP_W-1:0] step_q, step_d;
  logic              step_exp;

  assign step_exp = (state_q == RUN) && (step_q == STEP_MAX);
`endif

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    amt_d   = amt_q;
    lr_d    = lr_q;
`ifdef ROT_CMD_AUTO_STEP_EN
    // Zero outside RUN, so entry into RUN always starts a fresh period.
    step_d = '0;
    if (state_q == RUN && !clr_p && !ld_p && !step_exp) begin
      step_d = step_q + 1'b1;
    end
`endif
    if (clr_p) begin
      state_d = LOAD_LO;
      a_d     = '0;
      amt_d   = '0;
      lr_d    = 1'b0;
    end else if (ld_p) begin
      case (state_q)
        LOAD_LO: begin
          a_d[7:0] = sw;
          state_d  = LOAD_HI;
        end
        LOAD_HI: begin
          a_d[15:8] = sw;
          state_d   = LOAD_CFG;
        end
        LOAD_CFG: begin
          amt_d   = sw[3:0];
          lr_d    = sw[4];
          state_d = RUN;
        end
        RUN: begin
          amt_d = amt_q + 1'b1;
        end
      endcase
    end
`ifdef ROT_CMD_AUTO_STEP_EN
    else if (step_exp) begin
      amt_d = amt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      pulse_q  <= '0;
      cnt_q    <= '0;
      state_q  <= LOAD_LO;
      a_q      <= '0;
      amt_q    <= '0;
      lr_q     <= 1'b0;
`ifdef ROT_CMD_AUTO_STEP_EN
      step_q   <= '0;
`endif
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      // Registered edge detect puts the pulse one cycle after the level change.
      pulse_q  <= db_q & ~db_dly_q;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      a_q      <= a_d;
      amt_q    <= amt_d;
      lr_q     <= lr_d;
`ifdef ROT_CMD_AUTO_STEP_EN
      step_q   <= step_d;
`endif
    end
  end

  assign a     = a_q;
  assign amt   = amt_q;
  assign lr    = lr_q;
  assign phase = state_q;
  assign valid = (state_q == RUN);

endmodule

// File: tb/tb_rot_cmd_loader.sv
// Directed bench for rot_cmd_loader with DB_TICKS=4, STEP_TICKS=8; a raw rise sampled at edge k updates outputs at edge k+7.
module tb_rot_cmd_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw;
  logic        btn_ld;
  logic        btn_clr;
  logic [15:0] a;
  logic [3:0]  amt;
  logic        lr;
  logic        valid;
  logic [1:0]  phase;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ROT_CMD_AUTO_STEP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  rot_cmd_loader #(.DB_TICKS(4), .STEP_TICKS(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .btn_ld  (btn_ld),
    .btn_clr (btn_clr),
    .a       (a),
    .amt     (amt),
    .lr      (lr),
    .valid   (valid),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  // Raises the buttons so the rise is sampled at the next edge k; returns at the negedge after edge k+6.
  task automatic drive_press(input logic [7:0] swv, input logic ld, input logic clr);
    @(negedge clk);
    sw      = swv;
    btn_ld  = ld;
    btn_clr = clr;
    repeat (7) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settle_edge;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_all;
    btn_ld  = 1'b0;
    btn_clr = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_ld(input logic [7:0] swv);
    drive_press(swv, 1'b1, 1'b0);
    settle_edge();
    release_all();
  endtask

  task automatic test_reset;
    rst_n = 1'b1; sw = 8'h00; btn_ld = 1'b0; btn_clr = 1'b0;
    #13 rst_n = 1'b0;
    #1;
    n_checks++; if (a !== 16'h0000) begin n_fail++; $display("FAIL reset_a: got %h want 0000", a); end
    n_checks++; if (amt !== 4'h0) begin n_fail++; $display("FAIL reset_amt: got %h want 0", amt); end
    n_checks++; if (lr !== 1'b0) begin n_fail++; $display("FAIL reset_lr: got %b want 0", lr); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", phase); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_load;
    drive_press(8'h34, 1'b1, 1'b0);
    n_checks++; if (phase !== 2'd0 || a !== 16'h0000) begin n_fail++; $display("FAIL lo_early: phase %0d a %h want 0 0000", phase, a); end
    settle_edge();
    n_checks++; if (phase !== 2'd1 || a !== 16'h0034) begin n_fail++; $display("FAIL lo_load: phase %0d a %h want 1 0034", phase, a); end
    release_all();

    drive_press(8'h12, 1'b1, 1'b0);
    n_checks++; if (phase !== 2'd1 || a !== 16'h0034) begin n_fail++; $display("FAIL hi_early: phase %0d a %h want 1 0034", phase, a); end
    settle_edge();
    n_checks++; if (phase !== 2'd2 || a !== 16'h1234) begin n_fail++; $display("FAIL hi_load: phase %0d a %h want 2 1234", phase, a); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL hi_valid: got %b want 0", valid); end
    release_all();

    drive_press(8'h15, 1'b1, 1'b0);
    n_checks++; if (phase !== 2'd2 || amt !== 4'h0 || lr !== 1'b0) begin n_fail++; $display("FAIL cfg_early: phase %0d amt %h lr %b want 2 0 0", phase, amt, lr); end
    settle_edge();
    n_checks++; if (phase !== 2'd3 || valid !== 1'b1) begin n_fail++; $display("FAIL cfg_phase: phase %0d valid %b want 3 1", phase, valid); end
    n_checks++; if (amt !== 4'h5 || lr !== 1'b1 || a !== 16'h1234) begin n_fail++; $display("FAIL cfg_load: amt %h lr %b a %h want 5 1 1234", amt, lr, a); end
    release_all();
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 10; i++) press_ld(8'hFF);
    n_checks++; if (amt !== 4'hF) begin n_fail++; $display("FAIL wrap_pre: amt %h want f", amt); end
    press_ld(8'h00);
    n_checks++; if (amt !== 4'h0) begin n_fail++; $display("FAIL wrap_amt: amt %h want 0", amt); end
    n_checks++; if (a !== 16'h1234 || lr !== 1'b1 || phase !== 2'd3) begin n_fail++; $display("FAIL wrap_hold: a %h lr %b phase %0d want 1234 1 3", a, lr, phase); end
  endtask

  task automatic test_bounce;
    drive_press(8'h00, 1'b0, 1'b1);
    settle_edge();
    n_checks++; if (phase !== 2'd0 || a !== 16'h0000 || amt !== 4'h0 || lr !== 1'b0) begin n_fail++; $display("FAIL clr_basic: phase %0d a %h amt %h lr %b want 0 0000 0 0", phase, a, amt, lr); end
    release_all();

    sw = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      btn_ld = 1'b1;
      repeat (3) @(negedge clk);
      btn_ld = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    n_checks++; if (phase !== 2'd0 || a !== 16'h0000) begin n_fail++; $display("FAIL bounce_reject: phase %0d a %h want 0 0000", phase, a); end

    btn_ld = 1'b1;
    repeat (10) @(negedge clk);
    release_all();
    n_checks++; if (phase !== 2'd1 || a !== 16'h005A) begin n_fail++; $display("FAIL bounce_hold: phase %0d a %h want 1 005a", phase, a); end
  endtask

  task automatic test_clear_priority;
    press_ld(8'h77);
    n_checks++; if (phase !== 2'd2 || a !== 16'h775A) begin n_fail++; $display("FAIL prio_setup: phase %0d a %h want 2 775a", phase, a); end

    drive_press(8'h1F, 1'b1, 1'b1);
    settle_edge();
    n_checks++; if (phase !== 2'd0 || valid !== 1'b0) begin n_fail++; $display("FAIL prio_phase: phase %0d valid %b want 0 0", phase, valid); end
    n_checks++; if (a !== 16'h0000 || amt !== 4'h0 || lr !== 1'b0) begin n_fail++; $display("FAIL prio_clear: a %h amt %h lr %b want 0000 0 0", a, amt, lr); end
    btn_ld = 1'b0;
    repeat (10) @(negedge clk);

    drive_press(8'hA5, 1'b1, 1'b1);
    settle_edge();
    n_checks++; if (phase !== 2'd1 || a !== 16'h00A5) begin n_fail++; $display("FAIL clr_held_ld: phase %0d a %h want 1 00a5", phase, a); end
    release_all();
  endtask

  task automatic test_auto_step;
    press_ld(8'h00);
    drive_press(8'h02, 1'b1, 1'b0);
    settle_edge();
    n_checks++; if (phase !== 2'd3 || amt !== 4'h2 || lr !== 1'b0) begin n_fail++; $display("FAIL step_entry: phase %0d amt %h lr %b want 3 2 0", phase, amt, lr); end
    btn_ld = 1'b0;
    repeat (23) @(posedge clk);
    @(negedge clk);
    n_checks++; if (amt !== (AUTO ? 4'h4 : 4'h2)) begin n_fail++; $display("FAIL step_23: amt %h want %h", amt, AUTO ? 4'h4 : 4'h2); end
    settle_edge();
    n_checks++; if (amt !== (AUTO ? 4'h5 : 4'h2)) begin n_fail++; $display("FAIL step_24: amt %h want %h", amt, AUTO ? 4'h5 : 4'h2); end

    btn_ld = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_checks++; if (amt !== (AUTO ? 4'h5 : 4'h2)) begin n_fail++; $display("FAIL step_pre_align: amt %h want %h", amt, AUTO ? 4'h5 : 4'h2); end
    settle_edge();
    n_checks++; if (amt !== (AUTO ? 4'h6 : 4'h3)) begin n_fail++; $display("FAIL step_align: amt %h want %h", amt, AUTO ? 4'h6 : 4'h3); end
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_checks++; if (amt !== (AUTO ? 4'h7 : 4'h3)) begin n_fail++; $display("FAIL step_after: amt %h want %h", amt, AUTO ? 4'h7 : 4'h3); end
    release_all();
  endtask

  task automatic test_reset_mid;
    sw     = 8'h3C;
    btn_ld = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (a !== 16'h0000 || amt !== 4'h0 || lr !== 1'b0) begin n_fail++; $display("FAIL mid_rst_regs: a %h amt %h lr %b want 0000 0 0", a, amt, lr); end
    n_checks++; if (phase !== 2'd0 || valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_phase: phase %0d valid %b want 0 0", phase, valid); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_checks++; if (phase !== 2'd0 || a !== 16'h0000) begin n_fail++; $display("FAIL redb_early: phase %0d a %h want 0 0000", phase, a); end
    settle_edge();
    n_checks++; if (phase !== 2'd1 || a !== 16'h003C) begin n_fail++; $display("FAIL redb_load: phase %0d a %h want 1 003c", phase, a); end
    release_all();
  endtask

  initial begin
    test_reset();
    test_full_load();
`ifndef ROT_CMD_AUTO_STEP_EN
    test_wrap();
`endif
    test_bounce();
    test_clear_priority();
    test_auto_step();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
